// File: rtl/decode_stage_latched.sv
// decode_stage_latched: instruction-decode stage with a register file
// (hardwired-zero r0), write-back data mux, same-cycle write-to-read bypass
// and an opcode-driven immediate extender. Operands, immediate and the
// illegal-opcode flag are captured on Dec_En so the execute stage sees
// stable values across all of its cycles.
module decode_stage_latched #(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 32
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [31:0]       Instr,
  input  logic              Dec_En,
  input  logic              RF_B_sel,
  input  logic              RF_WrEn,
  input  logic [4:0]        Wr_Addr,
  input  logic              RF_WrData_sel,
  input  logic [DATA_W-1:0] ALU_out,
  input  logic [DATA_W-1:0] MEM_out,
  output logic [DATA_W-1:0] RF_A,
  output logic [DATA_W-1:0] RF_B,
  output logic [DATA_W-1:0] Immed,
  output logic              Illegal_Op,
  output logic              Dec_Valid
);

  localparam int ADDR_W = $clog2(REG_CNT);

  localparam logic [5:0] OP_LI   = 6'b111000;
  localparam logic [5:0] OP_ADDI = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b001111;
  localparam logic [5:0] OP_SW   = 6'b011111;
  localparam logic [5:0] OP_ANDI = 6'b110010;
  localparam logic [5:0] OP_ORI  = 6'b110011;
  localparam logic [5:0] OP_LUI  = 6'b111001;
  localparam logic [5:0] OP_B    = 6'b111111;
  localparam logic [5:0] OP_BEQ  = 6'b000000;
  localparam logic [5:0] OP_BNE  = 6'b000001;
  localparam logic [5:0] OP_RTYP = 6'b100000;

  logic [DATA_W-1:0] rf_q [REG_CNT];

  logic [5:0]        opcode;
  logic [15:0]       imm;
  logic [ADDR_W-1:0] ra_addr;
  logic [ADDR_W-1:0] rb_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_fire;
  logic [DATA_W-1:0] wd;

  logic [DATA_W-1:0] rf_a_d, rf_b_d, immed_d;
  logic              illegal_d;
  logic [DATA_W-1:0] rf_a_q, rf_b_q, immed_q;
  logic              illegal_q, dec_valid_q;

  // Upper address bits are deliberately ignored when REG_CNT < 32.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{Instr[25:21], Wr_Addr};

  function automatic logic [DATA_W-1:0] sext16(input logic [15:0] v);
    logic [DATA_W-1:0] r;
    r       = {DATA_W{v[15]}};
    r[15:0] = v;
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] zext16(input logic [15:0] v);
    logic [DATA_W-1:0] r;
    r       = '0;
    r[15:0] = v;
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] upper16(input logic [15:0] v);
    logic [DATA_W-1:0] r;
    r        = '0;
    r[31:16] = v;
    return r;
  endfunction

  assign opcode  = Instr[31:26];
  assign imm     = Instr[15:0];
  assign ra_addr = Instr[21 +: ADDR_W];
  assign rb_addr = RF_B_sel ? Instr[16 +: ADDR_W] : Instr[11 +: ADDR_W];
  assign wr_addr = Wr_Addr[ADDR_W-1:0];
  assign wd      = RF_WrData_sel ? MEM_out : ALU_out;
  // A write to r0 is dropped entirely, so it must not feed the bypass either.
  assign wr_fire = RF_WrEn && (wr_addr != '0);

  // Register file storage; r0 is never written so it stays at its reset value.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < REG_CNT; i++) rf_q[i] <= '0;
    end else if (wr_fire) begin
      rf_q[wr_addr] <= wd;
    end
  end

  // Read ports: r0 forced to zero, then same-cycle bypass, then storage.
  always_comb begin
    rf_a_d = rf_q[ra_addr];
    if (ra_addr == '0)                          rf_a_d = '0;
    else if (wr_fire && (ra_addr == wr_addr))   rf_a_d = wd;

    rf_b_d = rf_q[rb_addr];
    if (rb_addr == '0)                          rf_b_d = '0;
    else if (wr_fire && (rb_addr == wr_addr))   rf_b_d = wd;
  end

  // Immediate extension selected by opcode; unknown opcodes flag illegal.
  always_comb begin
    immed_d   = '0;
    illegal_d = 1'b0;
    case (opcode)
      OP_LI, OP_ADDI, OP_LW, OP_SW: immed_d = sext16(imm);
      OP_ANDI, OP_ORI:              immed_d = zext16(imm);
      OP_LUI:                       immed_d = upper16(imm);
      OP_B, OP_BEQ, OP_BNE:         immed_d = sext16(imm) << 2;
      OP_RTYP:                      immed_d = '0;
      default:                      illegal_d = 1'b1;
    endcase
  end

  // Decode output capture on Dec_En; values hold otherwise.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rf_a_q    <= '0;
      rf_b_q    <= '0;
      immed_q   <= '0;
      illegal_q <= 1'b0;
    end else if (Dec_En) begin
      rf_a_q    <= rf_a_d;
      rf_b_q    <= rf_b_d;
      immed_q   <= immed_d;
      illegal_q <= illegal_d;
    end
  end

  // Dec_Valid marks the cycle after each capture.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) dec_valid_q <= 1'b0;
    else        dec_valid_q <= Dec_En;
  end

  assign RF_A       = rf_a_q;
  assign RF_B       = rf_b_q;
  assign Immed      = immed_q;
  assign Illegal_Op = illegal_q;
  assign Dec_Valid  = dec_valid_q;

endmodule

// File: tb/tb_decode_stage_latched.sv
// Testbench for decode_stage_latched: a default 32x32 instance and a
// DATA_W=64 / REG_CNT=8 instance share one stimulus stream; expected
// captures are queued when driven and compared when Dec_Valid appears.
module tb_decode_stage_latched;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic [31:0] Instr;
  logic        Dec_En, RF_B_sel, RF_WrEn, RF_WrData_sel;
  logic [4:0]  Wr_Addr;
  logic [31:0] ALU_out, MEM_out, RF_A, RF_B, Immed;
  logic        Illegal_Op, Dec_Valid;
  logic [63:0] ALU_out64, MEM_out64, RF_A64, RF_B64, Immed64;
  logic        Illegal_Op64, Dec_Valid64;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        wide;
    logic [63:0] a, b, imm;
    logic        ill;
  } exp_t;
  exp_t sb[$];

  localparam logic [5:0] OP_LI = 6'b111000, OP_ADDI = 6'b110000, OP_LW = 6'b001111;
  localparam logic [5:0] OP_ANDI = 6'b110010, OP_ORI = 6'b110011, OP_LUI = 6'b111001;
  localparam logic [5:0] OP_B = 6'b111111, OP_BEQ = 6'b000000, OP_RTYP = 6'b100000;
  localparam logic [5:0] OP_BAD = 6'b101010;

  always #5 Clk = ~Clk;

  decode_stage_latched dut32 (
    .Clk(Clk), .Rst_n(Rst_n), .Instr(Instr), .Dec_En(Dec_En), .RF_B_sel(RF_B_sel),
    .RF_WrEn(RF_WrEn), .Wr_Addr(Wr_Addr), .RF_WrData_sel(RF_WrData_sel),
    .ALU_out(ALU_out), .MEM_out(MEM_out), .RF_A(RF_A), .RF_B(RF_B), .Immed(Immed),
    .Illegal_Op(Illegal_Op), .Dec_Valid(Dec_Valid)
  );

  decode_stage_latched #(.DATA_W(64), .REG_CNT(8)) dut64 (
    .Clk(Clk), .Rst_n(Rst_n), .Instr(Instr), .Dec_En(Dec_En), .RF_B_sel(RF_B_sel),
    .RF_WrEn(RF_WrEn), .Wr_Addr(Wr_Addr), .RF_WrData_sel(RF_WrData_sel),
    .ALU_out(ALU_out64), .MEM_out(MEM_out64), .RF_A(RF_A64), .RF_B(RF_B64), .Immed(Immed64),
    .Illegal_Op(Illegal_Op64), .Dec_Valid(Dec_Valid64)
  );

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [15:0] im);
    return {op, rs, rt, im};
  endfunction

  // Observed capture registers of the selected instance, widened to 64 bits.
  function automatic logic [192:0] obs(input logic wide);
    if (wide) return {RF_A64, RF_B64, Immed64, Illegal_Op64};
    return {32'h0, RF_A, 32'h0, RF_B, 32'h0, Immed, Illegal_Op};
  endfunction

  function automatic logic obs_vld(input logic wide);
    return wide ? Dec_Valid64 : Dec_Valid;
  endfunction

  // Drive one cycle of inputs at a falling edge and return at the next falling edge.
  task automatic cyc(input logic [31:0] ins, input logic en, input logic bsel,
                     input logic wen, input logic [4:0] wa, input logic wsel,
                     input logic [63:0] alu, input logic [63:0] mem);
    @(negedge Clk);
    Instr = ins; Dec_En = en; RF_B_sel = bsel; RF_WrEn = wen; Wr_Addr = wa;
    RF_WrData_sel = wsel; ALU_out = alu[31:0]; MEM_out = mem[31:0];
    ALU_out64 = alu; MEM_out64 = mem;
    @(negedge Clk);
    Dec_En = 1'b0; RF_WrEn = 1'b0;
  endtask

  task automatic test_reset;
    Rst_n = 1'b0; Instr = '0; Dec_En = 0; RF_B_sel = 0; RF_WrEn = 0; Wr_Addr = '0;
    RF_WrData_sel = 0; ALU_out = '0; MEM_out = '0; ALU_out64 = '0; MEM_out64 = '0;
    #2;
    checks++;
    if ({obs(1'b0), Dec_Valid, obs(1'b1), Dec_Valid64} !== '0) begin
      errors++;
      $display("FAIL reset_state: got %h/%b %h/%b required all zero",
               obs(1'b0), Dec_Valid, obs(1'b1), Dec_Valid64);
    end
    @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  task automatic test_write_read;
    exp_t e;
    cyc(32'h0, 0, 0, 1, 5'd5, 0, 64'hDEADBEEF, 64'h0);
    sb.push_back('{"write_read", 1'b0, 64'hDEADBEEF, 64'h0, 64'h0, 1'b0});
    cyc(mk(OP_RTYP, 5'd5, 5'd9, 16'h0000), 1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (!Dec_Valid) begin
      errors++; void'(sb.pop_front());
      $display("FAIL write_read: Dec_Valid got 0 required 1");
    end else begin
      e = sb.pop_front();
      if (obs(e.wide) !== {e.a, e.b, e.imm, e.ill}) begin
        errors++;
        $display("FAIL %s: got %h required %h", e.name, obs(e.wide), {e.a, e.b, e.imm, e.ill});
      end
    end
    cyc(32'h0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (Dec_Valid !== 1'b0) begin
      errors++; $display("FAIL valid_pulse: Dec_Valid got %b required 0", Dec_Valid);
    end
  endtask

  task automatic test_bypass;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: begin
          sb.push_back('{"bypass_r7", 1'b0, 64'h12345678, 64'h12345678, 64'h0, 1'b0});
          cyc(mk(OP_RTYP, 5'd7, 5'd7, 16'h0), 1, 1, 1, 5'd7, 1, 64'hAAAAAAAA, 64'h12345678);
        end
        1: begin
          sb.push_back('{"write_r0_bypass", 1'b0, 64'h0, 64'h0, 64'h0, 1'b0});
          cyc(mk(OP_RTYP, 5'd0, 5'd0, 16'h0), 1, 1, 1, 5'd0, 0, 64'hFFFFFFFF, 64'h0);
        end
        2: begin
          sb.push_back('{"r0_reads_zero", 1'b0, 64'h0, 64'h0, 64'h0, 1'b0});
          cyc(mk(OP_RTYP, 5'd0, 5'd0, 16'h0), 1, 1, 0, 0, 0, 0, 0);
        end
        default: begin
          sb.push_back('{"r7_stored", 1'b0, 64'h12345678, 64'hDEADBEEF, 64'h0, 1'b0});
          cyc(mk(OP_RTYP, 5'd7, 5'd5, 16'h0), 1, 1, 0, 0, 0, 0, 0);
        end
      endcase
      checks++;
      if (!Dec_Valid) begin
        errors++; void'(sb.pop_front());
        $display("FAIL bypass step %0d: Dec_Valid got 0 required 1", i);
      end else begin
        e = sb.pop_front();
        if (obs(e.wide) !== {e.a, e.b, e.imm, e.ill}) begin
          errors++;
          $display("FAIL %s: got %h required %h", e.name, obs(e.wide), {e.a, e.b, e.imm, e.ill});
        end
      end
    end
  endtask

  // Back-to-back captures: Dec_En held high across the whole table.
  task automatic test_immed;
    logic [5:0]  ops  [9] = '{OP_ADDI, OP_ANDI, OP_LUI, OP_BEQ, OP_BAD, OP_ORI, OP_LI, OP_B, OP_RTYP};
    logic [31:0] imms [9] = '{32'hFFFF8004, 32'h00008004, 32'h80040000, 32'hFFFE0010, 32'h0,
                              32'h00008004, 32'hFFFF8004, 32'hFFFE0010, 32'h0};
    exp_t e;
    @(negedge Clk);
    for (int i = 0; i < 9; i++) begin
      Instr = mk(ops[i], 5'd0, 5'd0, 16'h8004); Dec_En = 1; RF_B_sel = 1; RF_WrEn = 0;
      sb.push_back('{$sformatf("immed_op_%b", ops[i]), 1'b0, 64'h0, 64'h0,
                     {32'h0, imms[i]}, ops[i] == OP_BAD});
      @(negedge Clk);
      checks++;
      if (!Dec_Valid) begin
        errors++; void'(sb.pop_front());
        $display("FAIL immed step %0d: Dec_Valid got 0 required 1", i);
      end else begin
        e = sb.pop_front();
        if (obs(e.wide) !== {e.a, e.b, e.imm, e.ill}) begin
          errors++;
          $display("FAIL %s: got %h required %h", e.name, obs(e.wide), {e.a, e.b, e.imm, e.ill});
        end
      end
    end
    Dec_En = 0;
  endtask

  task automatic test_hold;
    exp_t e;
    sb.push_back('{"hold_capture", 1'b0, 64'h12345678, 64'h0, 64'h1, 1'b0});
    cyc(mk(OP_ADDI, 5'd7, 5'd0, 16'h0001), 1, 1, 0, 0, 0, 0, 0);
    checks++;
    if (!Dec_Valid) begin
      errors++; void'(sb.pop_front());
      $display("FAIL hold_capture: Dec_Valid got 0 required 1");
    end else begin
      e = sb.pop_front();
      if (obs(e.wide) !== {e.a, e.b, e.imm, e.ill}) begin
        errors++;
        $display("FAIL %s: got %h required %h", e.name, obs(e.wide), {e.a, e.b, e.imm, e.ill});
      end
    end
    for (int i = 0; i < 3; i++) begin
      cyc(mk(OP_LUI, 5'd7, 5'd5, 16'h1234 + 16'(i)), 0, 1, 1, 5'd7, 0, 64'h55555555, 0);
      checks++;
      if ({obs(1'b0), Dec_Valid} !== {32'h0, 32'h12345678, 64'h0, 64'h1, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL hold_%0d: got %h/%b required held values, Dec_Valid 0", i, obs(1'b0), Dec_Valid);
      end
    end
  endtask

  task automatic test_reset_mid;
    exp_t e;
    cyc(32'h0, 0, 0, 1, 5'd3, 0, 64'h33, 0);
    @(negedge Clk);
    Instr = mk(OP_RTYP, 5'd3, 5'd4, 16'h0); Dec_En = 1; RF_B_sel = 1;
    RF_WrEn = 1; Wr_Addr = 5'd4; RF_WrData_sel = 0; ALU_out = 32'h44; ALU_out64 = 64'h44;
    #2 Rst_n = 1'b0;
    #1;
    checks++;
    if ({obs(1'b0), Dec_Valid} !== '0) begin
      errors++; $display("FAIL reset_async: got %h/%b required all zero", obs(1'b0), Dec_Valid);
    end
    @(posedge Clk);
    #2 Rst_n = 1'b1; Dec_En = 0; RF_WrEn = 0;
    @(negedge Clk);
    checks++;
    if ({obs(1'b0), Dec_Valid} !== '0) begin
      errors++; $display("FAIL reset_discard: got %h/%b required all zero", obs(1'b0), Dec_Valid);
    end
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{$sformatf("post_reset_read_%0d", i), 1'b0, 64'h0, 64'h0, 64'h0, 1'b0});
      case (i)
        0:       cyc(mk(OP_RTYP, 5'd3, 5'd4, 16'h0), 1, 1, 0, 0, 0, 0, 0);
        1:       cyc(mk(OP_RTYP, 5'd7, 5'd5, 16'h0), 1, 1, 0, 0, 0, 0, 0);
        default: cyc(mk(OP_RTYP, 5'd5, 5'd13, 16'h0), 1, 1, 0, 0, 0, 0, 0);
      endcase
      checks++;
      if (!Dec_Valid) begin
        errors++; void'(sb.pop_front());
        $display("FAIL post_reset step %0d: Dec_Valid got 0 required 1", i);
      end else begin
        e = sb.pop_front();
        if (obs(e.wide) !== {e.a, e.b, e.imm, e.ill}) begin
          errors++;
          $display("FAIL %s: got %h required %h", e.name, obs(e.wide), {e.a, e.b, e.imm, e.ill});
        end
      end
    end
  endtask

  task automatic test_wide;
    exp_t e;
    cyc(32'h0, 0, 0, 1, 5'd13, 0, 64'h0123456789ABCDEF, 0);
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: begin
          sb.push_back('{"wide_addr_trunc", 1'b1, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 64'h0, 1'b0});
          cyc(mk(OP_RTYP, 5'd5, 5'd13, 16'h0), 1, 1, 0, 0, 0, 0, 0);
        end
        1: begin
          sb.push_back('{"wide_addi_ffff", 1'b1, 64'h0, 64'h0, 64'hFFFFFFFFFFFFFFFF, 1'b0});
          cyc(mk(OP_ADDI, 5'd0, 5'd0, 16'hFFFF), 1, 1, 0, 0, 0, 0, 0);
        end
        2: begin
          sb.push_back('{"wide_lui_8000", 1'b1, 64'h0, 64'h0, 64'h0000000080000000, 1'b0});
          cyc(mk(OP_LUI, 5'd0, 5'd0, 16'h8000), 1, 1, 0, 0, 0, 0, 0);
        end
        3: begin
          sb.push_back('{"wide_beq", 1'b1, 64'h0, 64'h0, 64'hFFFFFFFFFFFE0010, 1'b0});
          cyc(mk(OP_BEQ, 5'd0, 5'd0, 16'h8004), 1, 1, 0, 0, 0, 0, 0);
        end
        4: begin
          sb.push_back('{"wide_lw_pos", 1'b1, 64'h0, 64'h0, 64'h0000000000007FFF, 1'b0});
          cyc(mk(OP_LW, 5'd0, 5'd0, 16'h7FFF), 1, 1, 0, 0, 0, 0, 0);
        end
        default: begin
          sb.push_back('{"wide_bypass_mem", 1'b1, 64'hCAFEF00D11223344, 64'h0123456789ABCDEF, 64'h0, 1'b0});
          cyc(mk(OP_RTYP, 5'd10, 5'd5, 16'h0), 1, 1, 1, 5'd2, 1, 64'h1, 64'hCAFEF00D11223344);
        end
      endcase
      checks++;
      if (!obs_vld(1'b1)) begin
        errors++; void'(sb.pop_front());
        $display("FAIL wide step %0d: Dec_Valid got 0 required 1", i);
      end else begin
        e = sb.pop_front();
        if (obs(e.wide) !== {e.a, e.b, e.imm, e.ill}) begin
          errors++;
          $display("FAIL %s: got %h required %h", e.name, obs(e.wide), {e.a, e.b, e.imm, e.ill});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_immed();
    test_hold();
    test_reset_mid();
    test_wide();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d entries left required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage_latched.md
# decode_stage_latched

Parametrised, registered instruction-decode stage for the multi-cycle MIPS datapath. It holds a REG_CNT × DATA_W register file with a hardwired-zero register 0, a write-back data mux and a same-cycle write-to-read bypass. It also contains an opcode-driven immediate extender. RF_A, RF_B, Immed and flags are captured into output registers on a decode-enable strobe, so the execute stage sees stable operands across all of its cycles.

## Interface
Parameters:
- DATA_W, 32, datapath width; legal range 32..64.
- REG_CNT, 32, number of architectural registers; power of two, 2..32. ADDR_W = log2(REG_CNT) is a derived localparam.

Ports:
- Clk  in  1  rising-edge clock.
- Rst_n  in  1  reset, asynchronous assert, active-low.
- Instr  in  32  current instruction. Fields: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], imm[15:0].
- Dec_En  in  1  capture decode outputs at this rising edge.
- RF_B_sel  in  1  port-B read address select: 0 = rd, 1 = rt.
- RF_WrEn  in  1  register-file write enable.
- Wr_Addr  in  5  write address from the write-back stage.
- RF_WrData_sel  in  1  write data select: 0 = ALU_out, 1 = MEM_out.
- ALU_out  in  DATA_W  ALU result for write-back.
- MEM_out  in  DATA_W  memory read data for write-back.
- RF_A  out  DATA_W  registered port-A operand.
- RF_B  out  DATA_W  registered port-B operand.
- Immed  out  DATA_W  registered extended immediate.
- Illegal_Op  out  1  registered flag: captured opcode is not in the table.
- Dec_Valid  out  1  one-cycle pulse in the cycle after each capture.

## Operation
- Register addresses use the low ADDR_W bits of every 5-bit field, including Wr_Addr. Upper bits are ignored.
- Port A reads rs. Port B reads RF_B_sel ? rt : rd.
- Write data WD = RF_WrData_sel ? MEM_out : ALU_out.
- Write: at a rising edge with RF_WrEn=1 and truncated Wr_Addr ≠ 0, the register is loaded with WD. Writes to register 0 are dropped.
- Read: register 0 always reads 0.
- Bypass: if RF_WrEn=1 and truncated Wr_Addr ≠ 0 equals a read address in the same cycle, that port presents WD instead of the stored value. A capture in that cycle therefore takes the new data.
- Immediate extension (sx = sign-extend imm to DATA_W, zx = zero-extend):
  - li 111000, addi 110000, lw 001111, sw 011111: Immed = sx.
  - andi 110010, ori 110011: Immed = zx.
  - lui 111001: imm placed in bits [31:16], all other bits 0.
  - b 111111, beq 000000, bne 000001: Immed = sx shifted left 2. Sign extension happens before the shift; bits shifted out of DATA_W are lost.
  - R-type 100000: Immed = 0, legal.
  - Any other opcode: Immed = 0, Illegal_Op = 1.
- Capture: at a rising edge with Dec_En=1, load RF_A, RF_B, Immed and Illegal_Op from the current combinational values. With Dec_En=0 these hold.
- Dec_Valid is a register loaded with Dec_En every cycle.

## Timing
- Reset (Rst_n=0): all register-file entries, RF_A, RF_B, Immed, Illegal_Op and Dec_Valid go to 0 immediately, without a clock edge.
- Reset asserted mid-operation discards any in-flight capture or write.
- After Rst_n deasserts, the first rising edge operates normally.
- Capture latency: outputs are valid one edge after Dec_En is sampled high, coincident with the Dec_Valid pulse.
- Write latency: a write at edge N is visible through storage from edge N onward, and through the bypass in the cycle of the write itself.
- Simultaneous write and capture on the same address: the capture takes WD (bypass).
- Back-to-back Dec_En: one capture per edge. Dec_Valid stays high continuously while Dec_En stays high.
- RF_WrEn=1 with Wr_Addr=0: no state change, and the bypass does not fire.
- Combinational paths: Instr/ALU_out/MEM_out → capture registers only. No combinational input-to-output path.

## Test plan
- Reset: write several registers, then pulse Rst_n low between edges → all outputs 0 at once, and every register reads 0 on the next capture.
- Write and read: write 0xDEADBEEF to r5 via ALU_out, then capture rs=5, rd=0 (RF_B_sel=0) → RF_A=0xDEADBEEF, RF_B=0, Dec_Valid pulses one cycle.
- Bypass and r0:
  - Same-cycle write of MEM_out=0x12345678 to r7 while capturing rs=7, rt=7 (RF_B_sel=1) → RF_A=RF_B=0x12345678.
  - Write 0xFFFFFFFF to r0 → r0 still reads 0.
- Immediate table with imm=0x8004:
  - addi → 0xFFFF8004.
  - andi → 0x00008004.
  - lui → 0x80040000.
  - beq → 0xFFFE0010.
  - opcode 101010 → Immed=0, Illegal_Op=1.
- Parameters DATA_W=64, REG_CNT=8:
  - Write to Wr_Addr=13 lands in r5.
  - addi with imm=0xFFFF → 0xFFFFFFFFFFFFFFFF.
  - lui with imm=0x8000 → 0x0000000080000000.
- Hold: Dec_En=0 while Instr and register contents change → RF_A, RF_B and Immed unchanged, Dec_Valid stays 0.
